apb_cmd_master: RTL and testbench
=================================

Name: apb_cmd_master

Overview:
- Read-side consumer of the bridge's command FIFO, sitting in the APB clock domain.
- Pops one command word per transfer and drives a single APB transfer from it, with a SETUP phase followed by an ACCESS phase.
- Pushes one response word per transfer into the response FIFO, which returns it to the AHB side.
- Adds a bounded-wait timeout so a hung slave cannot stall the bridge.

Parameters:
ADDR_WIDTH, 32, APB address width
DATA_WIDTH, 32, APB data width
TIMEOUT, 16, max ACCESS cycles with pready low before abort; 0 disables timeout
CMD_WIDTH, ADDR_WIDTH+DATA_WIDTH+1, command word width, format {write, addr, wdata}

Ports:
rclk  input  1  APB-domain clock, also the FIFO read clock
reset  input  1  synchronous, active-high reset
cmd_rdata  input  CMD_WIDTH  command FIFO head word; show-ahead, valid whenever cmd_r_empty=0
cmd_r_empty  input  1  command FIFO empty
cmd_ren  output  1  command FIFO pop strobe
rsp_wdata  output  DATA_WIDTH+1  response word {err, rdata}
rsp_w_full  input  1  response FIFO full
rsp_wen  output  1  response FIFO push strobe
paddr  output  ADDR_WIDTH  APB address
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
pwdata  output  DATA_WIDTH  APB write data
prdata  input  DATA_WIDTH  APB read data
pready  input  1  APB ready
pslverr  input  1  APB slave error
busy  output  1  high whenever state is not IDLE
txn_count  output  16  count of completed responses, wraps at 0xFFFF->0

Behaviour:
- Reset is synchronous and active-high and acts on the next rclk edge.
  - State goes to IDLE.
  - psel, penable, pwrite, cmd_ren and rsp_wen go to 0.
  - paddr, pwdata, rsp_wdata and txn_count go to 0.
  - The timeout counter goes to 0.
- The FSM has four states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ren = (state==IDLE && !cmd_r_empty), combinational, one cycle.
  - In that same cycle, latch write, addr and wdata from cmd_rdata, then go to SETUP.
  - If cmd_r_empty=1, stay in IDLE with no pop.
- SETUP:
  - psel=1, penable=0.
  - paddr = latched addr, pwrite = latched write.
  - pwdata = latched wdata for writes, 0 for reads.
  - Lasts exactly 1 cycle, then go to ACCESS.
- ACCESS:
  - psel=1, penable=1; paddr, pwrite and pwdata are held stable.
  - When pready=1: capture rdata = (pwrite ? 0 : prdata) and err = pslverr, then go to RESP.
  - When pready=0: increment the timeout counter.
  - If TIMEOUT>0 and pready is still 0 on the TIMEOUT-th ACCESS cycle: capture rdata=0, err=1, then go to RESP.
  - The timeout counter clears on entry to SETUP.
- RESP:
  - psel=0, penable=0.
  - rsp_wdata = {err, rdata}.
  - rsp_wen = (state==RESP && !rsp_w_full), combinational.
  - On push: increment txn_count and go to IDLE.
  - While rsp_w_full=1: hold RESP and do not pop a new command.
- psel and penable are decoded from the registered state and have no glitches. penable is never 1 without psel.
- Every write and every read produces exactly one response.
- Latency from cmd_r_empty falling (in IDLE) to psel=1 is 1 cycle.
- The minimum transfer is 4 cycles: IDLE, SETUP, ACCESS, RESP. The next pop can occur 4 cycles after the previous pop.
- Exactly one pop and one push per transfer; no pipelining or overlap of transfers.
- Reset mid-operation:
  - An in-flight command that has already been popped is discarded, and no response is pushed.
  - APB signals drop to 0 at the reset edge.
- pslverr is sampled only when pready=1 in ACCESS and is ignored otherwise.
- prdata is ignored for writes.
- Simultaneous pready=1 and timeout expiry in the same cycle: pready wins, a normal completion.
- The timeout counter width is $clog2(TIMEOUT+1), with a minimum of 1.
- txn_count wraps with no saturation.

Test Plan:
- Write, pready=1: command {1, 0x0000_0010, 0xDEAD_BEEF} arrives.
  - cmd_ren pulses once.
  - Next cycle: psel=1, penable=0, paddr=0x10, pwrite=1, pwdata=0xDEADBEEF.
  - Following cycle: penable=1.
  - Then one rsp_wen with rsp_wdata={0, 0x0}; txn_count=1.
- Read with 3 wait states: pready=0 for 3 ACCESS cycles, then prdata=0x1234_5678 with pready=1.
  - ACCESS lasts 4 cycles with paddr and pwrite held.
  - Response is {0, 0x1234_5678}.
- Slave error on read: pslverr=1 with pready=1.
  - Response is {1, prdata}; the FSM returns to IDLE normally.
- Timeout with TIMEOUT=8 and pready held 0:
  - After 8 ACCESS cycles psel and penable drop.
  - Response is {1, 0x0}.
  - With TIMEOUT=0 the same stimulus hangs in ACCESS for 100 cycles with no response.
- Back-to-back commands: two queued commands, pready=1.
  - psel rises for the second transfer exactly 4 cycles after the first.
  - Holding rsp_w_full=1 for 5 cycles: stays in RESP, no cmd_ren, no rsp_wen; then exactly one push after release.
- Reset mid-ACCESS:
  - Next edge: psel=0, penable=0, busy=0.
  - No rsp_wen is issued and txn_count=0.
  - The next command executes normally afterward.

Source files
------------

// File: rtl/apb_cmd_master.sv
// APB master that pops {write, addr, wdata} commands from a show-ahead FIFO,
// runs one SETUP/ACCESS transfer per command and pushes an {err, rdata} response.
module apb_cmd_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16,
    parameter int CMD_WIDTH  = ADDR_WIDTH + DATA_WIDTH + 1
) (
    input  logic                  rclk,
    input  logic                  reset,
    input  logic [CMD_WIDTH-1:0]  cmd_rdata,
    input  logic                  cmd_r_empty,
    output logic                  cmd_ren,
    output logic [DATA_WIDTH:0]   rsp_wdata,
    input  logic                  rsp_w_full,
    output logic                  rsp_wen,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr,
    output logic                  busy,
    output logic [15:0]           txn_count
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                state_reg, state_next;
    logic [TW-1:0]         tmo_reg;
    logic [ADDR_WIDTH-1:0] paddr_reg;
    logic                  pwrite_reg;
    logic [DATA_WIDTH-1:0] pwdata_reg;
    logic [DATA_WIDTH:0]   rsp_reg;
    logic [15:0]           txn_reg;
    logic [DATA_WIDTH-1:0] rdata_sel;
    logic                  timed_out;

    // tmo_reg counts the wait cycles already spent, so it equals TIMEOUT-1
    // exactly on the TIMEOUT-th ACCESS cycle.
    assign timed_out = (TIMEOUT > 0) && (tmo_reg == TO_LAST);
    assign rdata_sel = pwrite_reg ? '0 : prdata;

    always_comb begin
        state_next = state_reg;
        cmd_ren    = 1'b0;
        rsp_wen    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!cmd_r_empty) begin
                    cmd_ren    = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP:  state_next = ACCESS;
            ACCESS: begin
                if (pready || timed_out) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (!rsp_w_full) begin
                    rsp_wen    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (reset) begin
            state_reg  <= IDLE;
            tmo_reg    <= '0;
            paddr_reg  <= '0;
            pwrite_reg <= 1'b0;
            pwdata_reg <= '0;
            rsp_reg    <= '0;
            txn_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (cmd_ren) begin
                pwrite_reg <= cmd_rdata[CMD_WIDTH-1];
                paddr_reg  <= cmd_rdata[DATA_WIDTH +: ADDR_WIDTH];
                pwdata_reg <= cmd_rdata[CMD_WIDTH-1] ? cmd_rdata[DATA_WIDTH-1:0] : '0;
                tmo_reg    <= '0;
            end
            if (state_reg == ACCESS) begin
                // A ready slave takes priority over a timeout expiring in the same cycle.
                if (pready) begin
                    rsp_reg <= {pslverr, rdata_sel};
                end else begin
                    tmo_reg <= tmo_reg + 1'b1;
                    if (timed_out) begin
                        rsp_reg <= {1'b1, {DATA_WIDTH{1'b0}}};
                    end
                end
            end
            if (rsp_wen) begin
                txn_reg <= txn_reg + 16'd1;
            end
        end
    end

    assign psel      = (state_reg == SETUP) || (state_reg == ACCESS);
    assign penable   = (state_reg == ACCESS);
    assign busy      = (state_reg != IDLE);
    assign paddr     = paddr_reg;
    assign pwrite    = pwrite_reg;
    assign pwdata    = pwdata_reg;
    assign rsp_wdata = rsp_reg;
    assign txn_count = txn_reg;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Scoreboard bench for apb_cmd_master: stimulus queues expected APB setups and
// responses, a monitor thread pops and compares them as the DUT presents them.
module tb_apb_cmd_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam int CW = AW + DW + 1;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [CW-1:0] cmd_rdata;
    logic          cmd_r_empty;
    logic          rsp_w_full;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    logic          cmd_ren, rsp_wen, psel, penable, pwrite, busy;
    logic [DW:0]   rsp_wdata;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [15:0]   txn_count;

    logic          cmd_ren0, rsp_wen0, psel0, penable0, pwrite0, busy0;
    logic [DW:0]   rsp_wdata0;
    logic [AW-1:0] paddr0;
    logic [DW-1:0] pwdata0;
    logic [15:0]   txn_count0;

    apb_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .rclk(clk), .reset(reset), .cmd_rdata(cmd_rdata), .cmd_r_empty(cmd_r_empty),
        .cmd_ren(cmd_ren), .rsp_wdata(rsp_wdata), .rsp_w_full(rsp_w_full), .rsp_wen(rsp_wen),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr), .busy(busy), .txn_count(txn_count)
    );

    // Same stimulus with the timeout disabled; it must hang where dut aborts.
    apb_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(0)) dut0 (
        .rclk(clk), .reset(reset), .cmd_rdata(cmd_rdata), .cmd_r_empty(cmd_r_empty),
        .cmd_ren(cmd_ren0), .rsp_wdata(rsp_wdata0), .rsp_w_full(rsp_w_full), .rsp_wen(rsp_wen0),
        .paddr(paddr0), .psel(psel0), .penable(penable0), .pwrite(pwrite0), .pwdata(pwdata0),
        .prdata(prdata), .pready(pready), .pslverr(pslverr), .busy(busy0), .txn_count(txn_count0)
    );

    int            vectors = 0;
    int            miscompares = 0;
    int            txn_model = 0;
    logic [CW-1:0] cmd_q[$];
    logic [CW-1:0] exp_apb[$];
    logic [DW:0]   exp_rsp[$];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic refresh();
        cmd_r_empty = (cmd_q.size() == 0);
        cmd_rdata   = cmd_r_empty ? '0 : cmd_q[0];
    endtask

    // One clock: a pop strobe seen before the edge retires the FIFO head after it.
    task automatic tick();
        logic pop_now;
        @(negedge clk);
        pop_now = cmd_ren;
        @(posedge clk);
        #1;
        if (pop_now && cmd_q.size() > 0) void'(cmd_q.pop_front());
        refresh();
        #1;
    endtask

    task automatic push_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d);
        cmd_q.push_back({wr, a, d});
        exp_apb.push_back({wr, a, wr ? d : 32'h0});
        refresh();
    endtask

    task automatic monitor();
        logic [CW-1:0] e_apb;
        logic [DW:0]   e_rsp;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (psel && !penable) begin
                    if (exp_apb.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL apb_setup: unexpected transfer addr %h, none expected", paddr);
                    end else begin
                        e_apb = exp_apb.pop_front();
                        chk("apb_setup", {pwrite, paddr, pwdata}, e_apb);
                    end
                end
                if (rsp_wen) begin
                    if (exp_rsp.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL rsp_word: unexpected push %h, none expected", rsp_wdata);
                    end else begin
                        e_rsp = exp_rsp.pop_front();
                        chk("rsp_word", rsp_wdata, e_rsp);
                        chk("rsp_count", txn_count, txn_model[15:0]);
                        txn_model++;
                    end
                end
            end
        end
    endtask

    // waits = ACCESS cycles with pready low before the completing cycle.
    task automatic do_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input int waits, input logic serr, input logic [31:0] rd);
        int n;
        int exp_n;
        n     = 0;
        exp_n = (waits >= TO) ? TO : waits + 1;
        if (waits >= TO) exp_rsp.push_back({1'b1, 32'h0});
        else             exp_rsp.push_back({serr, wr ? 32'h0 : rd});
        pready  = 1'b0;
        pslverr = ~serr;
        prdata  = 32'hBAD0_0000;
        push_cmd(wr, a, d);
        #1;
        chk("pop_strobe", cmd_ren, 1);
        tick();
        chk("setup_phase", {psel, penable, busy}, 3'b101);
        tick();
        while (psel && penable && n < 40) begin
            n++;
            chk("access_hold", {paddr, pwrite}, {a, wr});
            if (n == waits + 1) begin
                pready  = 1'b1;
                pslverr = serr;
                prdata  = rd;
            end else begin
                prdata = 32'hBAD0_0000 + n;
            end
            #1;
            tick();
        end
        chk("access_cycles", n, exp_n);
        chk("resp_strobe", {psel, penable, rsp_wen, busy}, 4'b0011);
        pready  = 1'b0;
        pslverr = 1'b0;
        tick();
        chk("back_idle", {busy, txn_count}, {1'b0, txn_model[15:0]});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hang_bad;
        reset      = 1'b1;
        rsp_w_full = 1'b0;
        prdata     = '0;
        pready     = 1'b0;
        pslverr    = 1'b0;
        refresh();
        fork
            monitor();
        join_none
        repeat (3) tick();
        chk("reset_ctl", {psel, penable, pwrite, cmd_ren, rsp_wen, busy, paddr, pwdata}, '0);
        chk("reset_rsp", {rsp_wdata, txn_count}, '0);
        reset = 1'b0;
        tick();

        do_xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b0, 32'h0);
        do_xfer(1'b0, 32'h0000_0020, 32'hFFFF_FFFF, 3, 1'b0, 32'h1234_5678);
        do_xfer(1'b0, 32'h0000_0040, 32'h0,         0, 1'b1, 32'hCAFE_F00D);
        do_xfer(1'b1, 32'h0000_0044, 32'hA5A5_5A5A, 1, 1'b1, 32'h5555_AAAA);
        do_xfer(1'b0, 32'h0000_0048, 32'h0,         7, 1'b0, 32'h0BAD_F00D);

        // Back-to-back commands, then response FIFO back-pressure.
        pready  = 1'b1;
        pslverr = 1'b0;
        prdata  = 32'h2222_2222;
        exp_rsp.push_back({1'b0, 32'h0});
        exp_rsp.push_back({1'b0, 32'h2222_2222});
        exp_rsp.push_back({1'b0, 32'h0});
        push_cmd(1'b1, 32'h100, 32'h1111_1111);
        push_cmd(1'b0, 32'h104, 32'hFFFF_FFFF);
        push_cmd(1'b1, 32'h108, 32'h3333_3333);
        #1;
        chk("b2b_pop_a", cmd_ren, 1);
        tick();
        chk("b2b_setup_a", {psel, penable, paddr}, {2'b10, 32'h100});
        tick();
        tick();
        tick();
        chk("b2b_pop_b", cmd_ren, 1);
        tick();
        chk("b2b_setup_b", {psel, penable, paddr}, {2'b10, 32'h104});
        rsp_w_full = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("full_hold", {busy, psel, cmd_ren, rsp_wen}, 4'b1000);
            if (i < 4) tick();
        end
        rsp_w_full = 1'b0;
        #1;
        chk("full_release", rsp_wen, 1);
        tick();
        chk("b2b_pop_c", cmd_ren, 1);
        repeat (4) tick();
        chk("b2b_done", {busy, txn_count}, {1'b0, txn_model[15:0]});

        // Reset while a read is stuck in ACCESS: command dropped, no response.
        pready = 1'b0;
        push_cmd(1'b0, 32'h200, 32'h0);
        #1;
        tick();
        tick();
        tick();
        chk("pre_reset_access", {psel, penable}, 2'b11);
        reset = 1'b1;
        tick();
        chk("mid_reset_apb", {psel, penable, busy, rsp_wen, paddr}, '0);
        chk("mid_reset_count", txn_count, 0);
        reset     = 1'b0;
        txn_model = 0;
        do_xfer(1'b0, 32'h0000_0060, 32'h0, 2, 1'b0, 32'h600D_CAFE);

        // Timeout: dut aborts after TO cycles, dut0 keeps waiting.
        do_xfer(1'b0, 32'h0000_0300, 32'h0, 100, 1'b0, 32'h0);
        hang_bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!(psel0 && penable0 && busy0) || rsp_wen0 || cmd_ren0) hang_bad++;
        end
        chk("t0_hang", hang_bad, 0);
        chk("t0_hold_apb", {paddr0, pwrite0, pwdata0}, {32'h300, 1'b0, 32'h0});
        chk("t0_hold_rsp", {rsp_wdata0, txn_count0}, {1'b0, 32'h600D_CAFE, 16'd1});

        chk("apb_q_drained", exp_apb.size(), 0);
        chk("rsp_q_drained", exp_rsp.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
